// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point result encoder: FSM states, format widths, bias helper.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int SHORT_EW  = 4;
  localparam int SHORT_FW  = 11;
  localparam int SINGLE_EW = 8;
  localparam int SINGLE_FW = 23;
  localparam int DOUBLE_EW = 11;
  localparam int DOUBLE_FW = 52;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and packing of an aligned mantissa into {sign, exp, frac}.
// With FP_PACK_FLAGS_EN defined it also reports flags_o = {overflow, underflow, inexact}.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EW = SINGLE_EW,
  parameter int FW = SINGLE_FW
) (
  input  logic                 sign_i,
  input  logic signed [EW+2:0] exp_i,
  input  logic [FW+4:0]        mant_i,
`ifdef FP_PACK_FLAGS_EN
  output logic [2:0]           flags_o,
`endif
  output logic [EW+FW:0]       data_o
);

  localparam int MW = FW + 5;
  localparam int XW = EW + 3;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_INF = XW'(2 * fp_bias(EW) + 1);

  logic                 lsb;
  logic                 grd;
  logic                 rs;
  logic                 up;
  logic                 hidden;
  logic                 is_inf;
  logic [MW-4:0]        sum_hi;
  logic signed [XW-1:0] exp_r;
  logic [FW-1:0]        frac;
  logic [EW-1:0]        exp_field;

  // Rounding adds at bit 3, so only the bits above guard/round/sticky take part in the sum.
  always_comb begin
    lsb    = mant_i[3];
    grd    = mant_i[2];
    rs     = mant_i[1] | mant_i[0];
    up     = grd & (rs | lsb);
    sum_hi = mant_i[MW-1:3] + {{(MW-4){1'b0}}, up};
    if (sum_hi[FW+1]) begin
      exp_r  = exp_i + EXP_ONE;
      hidden = 1'b1;
      frac   = sum_hi[FW:1];
    end else begin
      exp_r  = exp_i;
      hidden = sum_hi[FW];
      frac   = sum_hi[FW-1:0];
    end
    is_inf    = hidden & (exp_r >= EXP_INF);
    exp_field = hidden ? exp_r[EW-1:0] : '0;
    if (is_inf) begin
      data_o = {sign_i, {EW{1'b1}}, {FW{1'b0}}};
    end else begin
      data_o = {sign_i, exp_field, frac};
    end
  end

`ifdef FP_PACK_FLAGS_EN
  logic inexact;
  assign inexact = grd | rs;
  assign flags_o = {is_inf, ~hidden & inexact, inexact};
`endif

endmodule

// File: rtl/fp_pack_norm.sv
// Iterative normaliser: one ALIGN shift per cycle, then RNE rounding and IEEE-style packing.
// Define FP_PACK_FLAGS_EN to add out_flags = {overflow, underflow, inexact}.
module fp_pack_norm
  import fp_pkg::*;
#(
  parameter int EW = SINGLE_EW,
  parameter int FW = SINGLE_FW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic [EW+1:0]   in_exp,
  input  logic [FW+4:0]   in_mant,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef FP_PACK_FLAGS_EN
  output logic [2:0]      out_flags,
`endif
  output logic [EW+FW:0]  out_data
);

  localparam int MW = FW + 5;
  localparam int XW = EW + 3;
  localparam int DW = 1 + EW + FW;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

  state_e               state_q, state_d;
  logic                 sign_q, sign_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [MW-1:0]        mant_q, mant_d;
  logic [DW-1:0]        data_q, data_d;
  logic [DW-1:0]        rnd_data;
  logic                 accept;
  logic                 shr;
  logic                 shl;

  assign accept = in_valid & in_ready;
  // Right shift has priority: it clears a carry bit or lifts a too-small exponent toward 1.
  assign shr    = mant_q[MW-1] | (exp_q < EXP_ONE);
  assign shl    = ~mant_q[FW+3] & (exp_q > EXP_ONE);

`ifdef FP_PACK_FLAGS_EN
  logic [2:0] flags_q, flags_d, rnd_flags;
`endif

  fp_round_rne #(
    .EW(EW),
    .FW(FW)
  ) u_round (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .mant_i (mant_q),
`ifdef FP_PACK_FLAGS_EN
    .flags_o(rnd_flags),
`endif
    .data_o (rnd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_mant == '0) ? OUT : ALIGN;
      ALIGN:   if (!shr && !shl) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
  end

  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    data_d = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = in_sign;
          exp_d  = {in_exp[EW+1], in_exp};
          mant_d = in_mant;
          data_d = {in_sign, {(DW-1){1'b0}}};
        end
      end
      ALIGN: begin
        if (shr) begin
          mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + EXP_ONE;
        end else if (shl) begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end
      ROUND:   data_d = rnd_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      data_q <= '0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      data_q <= data_d;
    end
  end

  assign out_data = data_q;

`ifdef FP_PACK_FLAGS_EN
  always_comb begin
    flags_d = flags_q;
    if (accept) begin
      flags_d = '0;
    end else if (state_q == ROUND) begin
      flags_d = rnd_flags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out_flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_pack_norm.sv
// Randomised and directed bench for fp_pack_norm against an arithmetic RNE reference model.
module tb_fp_pack_norm;

  localparam int EW = 8;
  localparam int FW = 23;
  localparam int MW = FW + 5;
  localparam int DW = 1 + EW + FW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [EW+1:0] in_exp = '0;
  logic [MW-1:0] in_mant = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef FP_PACK_FLAGS_EN
  logic [2:0]    out_flags;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_pack_norm #(.EW(EW), .FW(FW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FP_PACK_FLAGS_EN
    .out_flags(out_flags),
`endif
    .out_data (out_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Returns {overflow, underflow, inexact, packed word}; value = m/2^(FW+3) * 2^(e-bias).
  function automatic logic [DW+2:0] ref_pack(input logic s, input int e_in, input logic [MW-1:0] m);
    longint        mm, q, rem;
    int            p, e, sh;
    logic          hid, inx, ovf;
    logic [EW-1:0] fld;
    logic [FW-1:0] frac;
    if (m == '0) return {3'b000, s, {(DW-1){1'b0}}};
    p = MW - 1;
    while (m[p] == 1'b0) p--;
    e = e_in + p - (FW + 3);
    if (e < 1) e = 1;
    sh = e - e_in;
    mm = longint'(m);
    if (sh >= MW) mm = 1;
    else if (sh > 0) mm = (mm >> sh) | longint'((mm & ((longint'(1) << sh) - 1)) != 0);
    else mm = mm << (-sh);
    q   = mm >> 3;
    rem = mm & 7;
    if (rem > 4 || (rem == 4 && q[0])) q = q + 1;
    if (q >= (longint'(1) << (FW + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    hid  = (q >= (longint'(1) << FW));
    inx  = (rem != 0);
    ovf  = hid && (e >= (1 << EW) - 1);
    fld  = hid ? e[EW-1:0] : '0;
    frac = q[FW-1:0];
    if (ovf) begin
      fld  = '1;
      frac = '0;
    end
    return {ovf, ~hid & inx, inx, s, fld, frac};
  endfunction

  task automatic run_op(input string tag, input logic s, input int e, input logic [MW-1:0] m,
                        input logic use_want, input logic [DW+2:0] want,
                        input int want_lat, input int hold);
    logic [DW+2:0] exp_v;
    int            cyc;
    exp_v = use_want ? want : ref_pack(s, e, m);
    cyc = 0;
    while (!in_ready && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e[EW+1:0];
    in_mant  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " vld"}, 64'(out_valid), 64'd1);
    if (want_lat > 0) check({tag, " lat"}, 64'(cyc), 64'(want_lat));
    check({tag, " data"}, 64'(out_data), 64'(exp_v[DW-1:0]));
`ifdef FP_PACK_FLAGS_EN
    check({tag, " flags"}, 64'(out_flags), 64'(exp_v[DW+2:DW]));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, 64'({in_ready, out_valid, out_data}), 64'({1'b0, 1'b1, exp_v[DW-1:0]}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " done"}, 64'({out_valid, in_ready}), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    int            e;
    logic          s;
    logic [MW-1:0] m;

    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    run_op("unity",      1'b0, 127, 28'h4000000, 1'b1, {3'b000, 32'h3F800000}, 3, 3);
    run_op("carry",      1'b0, 127, 28'h8000000, 1'b1, {3'b000, 32'h40000000}, 4, 0);
    run_op("left",       1'b0, 130, 28'h1000000, 1'b1, {3'b000, 32'h40000000}, 5, 0);
    run_op("tie even",   1'b0, 127, 28'h4000004, 1'b1, {3'b001, 32'h3F800000}, 3, 0);
    run_op("round up",   1'b0, 127, 28'h400000C, 1'b1, {3'b001, 32'h3F800002}, 3, 0);
    run_op("overflow",   1'b0, 254, 28'h7FFFFFF, 1'b1, {3'b101, 32'h7F800000}, 3, 0);
    run_op("zero",       1'b1, 0,   28'h0000000, 1'b1, {3'b000, 32'h80000000}, 1, 0);
    run_op("denorm",     1'b0, 0,   28'h4000000, 1'b1, {3'b000, 32'h00400000}, 4, 0);
    run_op("denorm inx", 1'b1, 0,   28'h4000001, 1'b1, {3'b011, 32'h80400000}, 4, 0);
    run_op("den->norm",  1'b0, 1,   28'h3FFFFFC, 1'b1, {3'b001, 32'h00800000}, 3, 0);

    // output consumed while the next operand is already presented
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_mant = 28'h4000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ovl first vld", 64'(out_valid), 64'd1);
    in_valid = 1'b1; in_exp = 10'd128; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovl consume only", 64'({out_valid, in_ready}), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ovl accepted", 64'(in_ready), 64'd0);
    cyc = 1;
    while (!out_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ovl lat", 64'(cyc), 64'd3);
    check("ovl data", 64'(out_data), 64'h40000000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset in the middle of a long right-shift sequence
    e = -100;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = e[EW+1:0]; in_mant = 28'h4000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("align busy", 64'(in_ready), 64'd0);
    #1 reset = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_data", 64'(out_data), 64'd0);
    #3 reset = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    check("rst no stale", 64'(out_valid), 64'd0);
    run_op("after rst", 1'b0, 127, 28'h4000000, 1'b1, {3'b000, 32'h3F800000}, 3, 0);

    for (int k = 0; k < 200; k++) begin
      s = 1'(($urandom() & 1));
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(240, 270));
      else e = int'($urandom_range(0, 330)) - 60;
      case ($urandom_range(0, 5))
        0: m = MW'($urandom());
        1: m = {2'b01, 26'($urandom())};
        2: m = MW'($urandom()) >> $urandom_range(1, 27);
        3: m = {2'b01, 23'($urandom()), 3'b100};
        4: m = {2'b00, 26'($urandom())};
        default: m = '0;
      endcase
      run_op("rand", s, e, m, 1'b0, '0, 0, int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_pack_norm.md
Name: fp_pack_norm

Overview:
- Result encoder on the output side of the floating-point datapath.
- Takes the sign, wide signed exponent and raw unnormalised mantissa produced by the arithmetic stages. Normalises iteratively, rounds to nearest-even and packs an IEEE-style word of (1, EW, FW) bits.
- Default is single precision. The short format uses EW=4, FW=11.
- Valid/ready on both sides, so it sits between the ALU core and the result registers.

Parameters:
- EW, 8, exponent field width; bias = 2^(EW-1)-1.
- FW, 23, fraction field width.
- MW (derived localparam), FW+5, raw mantissa width. Bit FW+3 is the hidden-one position, bit FW+4 is the carry bit, bits [2:0] are guard/round/sticky.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept.
- in_sign  in  1  sign.
- in_exp  in  EW+2  signed biased exponent.
- in_mant  in  MW  raw mantissa; value = in_mant/2^(FW+3) * 2^(in_exp-bias).
- out_valid  out  1  packed result present.
- out_ready  in  1  consumer accepts.
- out_data  out  1+EW+FW  {sign, exp field, fraction}.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, all internal registers 0. Reset asserted mid-operation discards the operation in flight.
- FSM IDLE:
  - in_ready=1.
  - in_valid&&in_ready captures sign, exp and mant into registers.
  - If mant==0, go to OUT with out_data={sign, 0...}. Otherwise go to ALIGN.
- FSM ALIGN (one shift per cycle, in_ready=0), priority order:
  - a) mant[MW-1]==1: shift right 1, OR the shifted-out bit into mant[0] (sticky), exp+1.
  - b) exp<1: shift right 1 with sticky, exp+1.
  - c) mant[FW+3]==0 && exp>1: shift left 1, exp-1.
  - d) otherwise go to ROUND.
  - The rules are exclusive per cycle.
  - Exit with exp==1 and hidden bit 0 means a denormal result.
- FSM ROUND (1 cycle):
  - lsb=mant[3], g=mant[2], rs=mant[1]|mant[0].
  - Round up iff g && (rs || lsb); add 1 at bit 3.
  - A carry into bit FW+4 sets exp+1 and takes the fraction from the shifted value.
  - A carry that turns a denormal into hidden=1 yields exp field 1.
  - Exp field: 0 if hidden bit clear, else exp.
  - If exp ≥ 2^EW-1: out_data = {sign, all-ones, 0} (infinity).
  - Then go to OUT.
- FSM OUT:
  - out_valid=1; out_data held stable while out_ready==0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 the next cycle.
- Latency, already-normalised input: capture edge + 1 ALIGN + 1 ROUND. out_valid rises 3 cycles after the accept edge.
- Each extra shift adds 1 cycle. Worst case is about MW+EW cycles.
- Throughput is one operation per (latency+1) cycles; there is no input buffering. in_valid while in_ready=0 is ignored.
- in_valid and out_ready asserted simultaneously in OUT: the output is consumed only. The input is accepted on the next cycle in IDLE.
- Infinity/NaN inputs are not handled here; the caller bypasses them.

Optional Feature:
- Macro FP_PACK_FLAGS_EN.
- When defined, adds output port out_flags [2:0] = {overflow, underflow, inexact}:
  - Flags are valid with out_valid and held with out_data.
  - overflow: infinity produced.
  - underflow: denormal or zero result with inexact set.
  - inexact: g|rs nonzero at ROUND.
  - Reset value 0.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Decomposition:
- Shared package fp_pkg holds:
  - state enum (IDLE, ALIGN, ROUND, OUT);
  - format constants: SHORT_EW=4/SHORT_FW=11, SINGLE_EW=8/SINGLE_FW=23, DOUBLE_EW=11/DOUBLE_FW=52;
  - bias function.
- One sub-module, fp_round_rne: combinational rounding, carry, exponent-field and infinity selection, instantiated in ROUND.

Test Plan (default parameters, MW=28):
- Unity: sign=0, exp=127, mant=28'h4000000 -> out_data=32'h3F800000; out_valid 3 cycles after accept.
- Carry normalise: exp=127, mant=28'h8000000 -> 32'h40000000 (one right shift).
- Left normalise: exp=130, mant=28'h1000000 -> 32'h40000000; two extra ALIGN cycles, latency 5.
- Tie and round-up:
  - mant=28'h4000004 (guard only, lsb 0) -> 32'h3F800000, inexact=1;
  - mant=28'h400000C -> 32'h3F800002.
- Overflow: exp=254, mant=28'h7FFFFFF -> rounding carry -> 32'h7F800000, overflow=1.
- Zero, back-pressure and reset:
  - sign=1, mant=0 -> 32'h80000000.
  - out_ready held low 3 cycles: out_data stable, in_ready=0.
  - reset pulsed low during ALIGN -> out_valid=0, in_ready=1 immediately.
